if_fetch_queue: RTL and testbench

//   Receiving end of the IF stage output (PC4/Instr) and source of StallF back into IF.
//   - Small in-order FIFO between IF and ID; absorbs decode stalls so IF keeps fetching.
//   - Presents the oldest instruction to ID with a valid flag.
//   - Discards all queued fetches on a control-flow redirect (Flush).

---
 rtl/if_fetch_queue.sv | 96 +++++++++
 tb/tb_if_fetch_queue.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// In-order fetch queue between IF and ID: buffers {PC4,Instr} pairs, shows the
// oldest entry to ID, and back-pressures IF with StallF. Optional: IF_FQ_BYPASS_EN.
module if_fetch_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [31:0]   PC4,
   input  logic [31:0]   Instr,
   input  logic          Flush,
   input  logic          StallD,
   output logic          StallF,
   output logic [31:0]   PC4_D,
   output logic [31:0]   Instr_D,
   output logic          ValidD,
   output logic [AW:0]   Count
);

   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [63:0]   mem_q [DEPTH];
   logic [63:0]   mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          empty, enq, deq, bypass, push, pop;

   always_comb begin
      empty  = (count_q == '0);
      StallF = (count_q == FULL);
      enq    = ~StallF & ~Flush;
`ifdef IF_FQ_BYPASS_EN
      bypass = empty & ~Flush;
`else
      bypass = 1'b0;
`endif
      // Head is show-ahead: the rd_ptr entry, the live fetch when bypassing, or a nop.
      if (bypass) begin
         ValidD  = 1'b1;
         PC4_D   = PC4;
         Instr_D = Instr;
      end else if (empty) begin
         ValidD  = 1'b0;
         PC4_D   = 32'h0;
         Instr_D = 32'h0;
      end else begin
         ValidD  = 1'b1;
         {PC4_D, Instr_D} = mem_q[rd_ptr_q];
      end
      deq = ValidD & ~StallD & ~Flush;
      // A bypassed fetch consumed by ID never touches storage.
      push = enq & ~(bypass & deq);
      pop  = deq & ~bypass;
      Count = count_q;
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (Flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = {PC4, Instr};
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is left uncleared by reset; Count alone gates its visibility.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed vector table, hand sequences and a random run,
// all cross-checked against a queue-based reference of the fetch queue.
module tb_if_fetch_queue;

   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic [31:0]   PC4, Instr;
   logic          Flush, StallD;
   logic          StallF, ValidD;
   logic [31:0]   PC4_D, Instr_D;
   logic [AW:0]   Count;

   int n_checks = 0;
   int n_pass   = 0;

   logic [63:0] exp_q[$];
   logic [31:0] f_pc, f_instr;

   typedef struct {
      logic        rst, fl, sd;
      logic [31:0] pc4, instr;
      bit          chk;
      logic        ev;
      logic [31:0] epc, einstr;
      logic [2:0]  ecnt;
      logic        esf;
   } vec_t;

   vec_t vecs[$];

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

   if_fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk    (clk),
      .reset  (reset),
      .PC4    (PC4),
      .Instr  (Instr),
      .Flush  (Flush),
      .StallD (StallD),
      .StallF (StallF),
      .PC4_D  (PC4_D),
      .Instr_D(Instr_D),
      .ValidD (ValidD),
      .Count  (Count)
   );

   // scoreboard
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic model_outputs(input logic fl, input logic [31:0] pc_in, input logic [31:0] ins_in,
                                output logic ev, output logic [31:0] epc, output logic [31:0] ei,
                                output logic [2:0] ec, output logic esf);
      esf = (exp_q.size() == DEPTH);
      ec  = 3'(exp_q.size());
      if (exp_q.size() > 0) begin
         ev  = 1'b1;
         epc = exp_q[0][63:32];
         ei  = exp_q[0][31:0];
      end else begin
`ifdef IF_FQ_BYPASS_EN
         ev  = !fl;
         epc = fl ? 32'h0 : pc_in;
         ei  = fl ? 32'h0 : ins_in;
`else
         ev  = 1'b0;
         epc = 32'h0;
         ei  = 32'h0;
`endif
      end
   endtask

   task automatic model_step(input logic rst, input logic fl, input logic sd,
                             input logic [31:0] pc_in, input logic [31:0] ins_in);
      int  n;
      bit  consumed;
      n = exp_q.size();
      consumed = 1'b0;
      if (!rst || fl) begin
         exp_q.delete();
      end else begin
`ifdef IF_FQ_BYPASS_EN
         if (n == 0 && !sd) consumed = 1'b1;
`endif
         if (!consumed) begin
            if (n > 0 && !sd) void'(exp_q.pop_front());
            if (n < DEPTH) exp_q.push_back({pc_in, ins_in});
         end
      end
   endtask

   // driver
   task automatic cycle(input logic rst, input logic fl, input logic sd,
                        input logic [31:0] pc_in, input logic [31:0] ins_in,
                        input bit do_chk, input string tag);
      logic        ev, esf;
      logic [31:0] epc, ei;
      logic [2:0]  ec;
      reset = rst; Flush = fl; StallD = sd; PC4 = pc_in; Instr = ins_in;
      @(negedge clk);
      if (do_chk) begin
         model_outputs(fl, pc_in, ins_in, ev, epc, ei, ec, esf);
         chk({tag, " ValidD"},  64'(ValidD),  64'(ev));
         chk({tag, " Instr_D"}, 64'(Instr_D), 64'(ei));
         chk({tag, " PC4_D"},   64'(PC4_D),   64'(epc));
         chk({tag, " Count"},   64'(Count),   64'(ec));
         chk({tag, " StallF"},  64'(StallF),  64'(esf));
      end
      @(posedge clk);
      model_step(rst, fl, sd, pc_in, ins_in);
      #1;
   endtask

   task automatic fetch_cycle(input logic rst, input logic fl, input logic sd, input string tag);
      bit acc;
      acc = rst && !fl && (exp_q.size() < DEPTH);
      cycle(rst, fl, sd, f_pc, f_instr, 1'b1, tag);
      if (acc) begin
         f_pc    = f_pc + 32'd4;
         f_instr = $urandom;
      end
   endtask

   task automatic apply_vec(input vec_t v, input int idx);
      reset = v.rst; Flush = v.fl; StallD = v.sd; PC4 = v.pc4; Instr = v.instr;
      @(negedge clk);
      if (v.chk) begin
         chk($sformatf("vec%0d ValidD", idx),  64'(ValidD),  64'(v.ev));
         chk($sformatf("vec%0d Instr_D", idx), 64'(Instr_D), 64'(v.einstr));
         chk($sformatf("vec%0d PC4_D", idx),   64'(PC4_D),   64'(v.epc));
         chk($sformatf("vec%0d Count", idx),   64'(Count),   64'(v.ecnt));
         chk($sformatf("vec%0d StallF", idx),  64'(StallF),  64'(v.esf));
      end
      @(posedge clk);
      model_step(v.rst, v.fl, v.sd, v.pc4, v.instr);
      #1;
   endtask

   function automatic vec_t mk(input logic rst, input logic fl, input logic sd,
                               input logic [31:0] pc4, input logic [31:0] instr, input bit c,
                               input logic ev, input logic [31:0] epc, input logic [31:0] ei,
                               input logic [2:0] ec, input logic esf);
      vec_t v;
      v = '{rst, fl, sd, pc4, instr, c, ev, epc, ei, ec, esf};
      return v;
   endfunction

   function automatic logic [31:0] ai(input int i);
      return 32'(32'h1000_0000 + i);
   endfunction

   function automatic logic [31:0] pa(input int i);
      return 32'(32'h0000_4004 + 4 * i);
   endfunction

   initial begin
      reset = 1'b0; Flush = 1'b0; StallD = 1'b0; PC4 = '0; Instr = '0;
      f_pc = 32'h0000_8004; f_instr = $urandom;

      // reset for two cycles; state is only defined after the first edge
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h1111_1111, 1'b0, "reset0");
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h1111_1111, 1'b1, "reset1");

`ifndef IF_FQ_BYPASS_EN
      // stream
      vecs.push_back(mk(1,0,0, 32'h3004, 32'h2008_0001, 1, 0, 32'h0,    32'h0,         0, 0));
      vecs.push_back(mk(1,0,0, 32'h3008, 32'h2009_0002, 1, 1, 32'h3004, 32'h2008_0001, 1, 0));
      vecs.push_back(mk(1,1,0, 32'h300c, 32'h200a_0003, 1, 1, 32'h3008, 32'h2009_0002, 1, 0));
      // fill under StallD, IF holds A4 while StallF
      vecs.push_back(mk(1,0,1, pa(0), ai(0), 1, 0, 32'h0, 32'h0, 0, 0));
      vecs.push_back(mk(1,0,1, pa(1), ai(1), 1, 1, pa(0), ai(0), 1, 0));
      vecs.push_back(mk(1,0,1, pa(2), ai(2), 1, 1, pa(0), ai(0), 2, 0));
      vecs.push_back(mk(1,0,1, pa(3), ai(3), 1, 1, pa(0), ai(0), 3, 0));
      vecs.push_back(mk(1,0,1, pa(4), ai(4), 1, 1, pa(0), ai(0), 4, 1));
      vecs.push_back(mk(1,0,1, pa(4), ai(4), 1, 1, pa(0), ai(0), 4, 1));
      // release: full queue refuses A4 even while dequeuing
      vecs.push_back(mk(1,0,0, pa(4), ai(4), 1, 1, pa(0), ai(0), 4, 1));
      vecs.push_back(mk(1,0,0, pa(4), ai(4), 1, 1, pa(1), ai(1), 3, 0));
      vecs.push_back(mk(1,0,0, pa(5), ai(5), 1, 1, pa(2), ai(2), 3, 0));
      vecs.push_back(mk(1,0,0, pa(6), ai(6), 1, 1, pa(3), ai(3), 3, 0));
      // flush at Count==3 with DEADBEEF presented, then it must not surface
      vecs.push_back(mk(1,1,0, 32'hbeef_0004, 32'hdead_beef, 1, 1, pa(4), ai(4), 3, 0));
      vecs.push_back(mk(1,0,1, 32'h5004, 32'h1234_5678, 1, 0, 32'h0, 32'h0, 0, 0));
      for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], i);
`endif

      // wrap: prefill then alternate StallD with continuous fetch
      for (int i = 0; i < 3; i++) fetch_cycle(1'b1, 1'b0, 1'b1, "wrap_fill");
      for (int i = 0; i < 10; i++) fetch_cycle(1'b1, 1'b0, 1'(i % 2), "wrap");
      for (int i = 0; i < 6; i++) fetch_cycle(1'b1, 1'b0, 1'b0, "wrap_drain");

      // reset while flushing a full queue
      for (int i = 0; i < 5; i++) fetch_cycle(1'b1, 1'b0, 1'b1, "full_fill");
      fetch_cycle(1'b0, 1'b1, 1'b0, "rst_flush");
      cycle(1'b1, 1'b0, 1'b0, 32'h0000_9004, 32'h8c01_0000, 1'b1, "post_rst");
      cycle(1'b1, 1'b0, 1'b1, 32'h0000_9008, 32'h8c02_0000, 1'b1, "post_rst2");
      cycle(1'b1, 1'b0, 1'b0, 32'h0000_900c, 32'h8c03_0000, 1'b1, "post_rst3");
      // reset mid-fill
      fetch_cycle(1'b1, 1'b0, 1'b1, "midfill");
      fetch_cycle(1'b0, 1'b0, 1'b1, "midfill_rst");
      fetch_cycle(1'b1, 1'b0, 1'b0, "midfill_after");

      // randomized run
      for (int i = 0; i < 400; i++) begin
         fetch_cycle(1'($urandom_range(0, 63) != 0), 1'($urandom_range(0, 15) == 0),
                     1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
